// File: rtl/isp_pkg.sv
// Shared ISP datapath types and helpers.
package isp_pkg;

   localparam int ISP_PIX_W = 8;

   typedef logic [ISP_PIX_W-1:0] pix_t;

   // Pointer width carries one extra wrap bit above the index.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/isp_offset_add.sv
// Combinational constant-offset adder for the ISP write path.
// Define ISP_OFFSET_SAT_EN to clamp at all-ones instead of wrapping.
module isp_offset_add #(
   parameter int          WIDTH  = 8,
   parameter int unsigned OFFSET = 1
) (
   input  logic [WIDTH-1:0] a_i,
   output logic [WIDTH-1:0] y_o
);

   localparam logic [WIDTH-1:0] OFF = WIDTH'(OFFSET);

`ifdef ISP_OFFSET_SAT_EN
   logic [WIDTH:0] sum;

   always_comb begin
      sum = {1'b0, a_i} + {1'b0, OFF};
      y_o = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
   end
`else
   always_comb begin
      y_o = a_i + OFF;
   end
`endif

endmodule

// File: rtl/isp_offset_fifo.sv
// Offset-on-ingress first-word-fall-through FIFO between ISP stages.
// Build option: ISP_OFFSET_SAT_EN selects a saturating offset add.
module isp_offset_fifo
   import isp_pkg::*;
#(
   parameter int          DATA_WIDTH = 8,
   parameter int          FIFO_DEPTH = 4,
   parameter int unsigned OFFSET     = 1,
   parameter int          CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  u_i_ready,
   input  logic                  u_r_ready,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  i_i_ready,
   output logic                  i_r_ready,
   output logic [CNT_WIDTH-1:0]  count
);

   localparam int PW = ptr_w(FIFO_DEPTH);
   localparam int IW = PW - 1;

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] last_q, last_d;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic                  full, empty, insert, remove;

   isp_offset_add #(
      .WIDTH  (DATA_WIDTH),
      .OFFSET (OFFSET)
   ) u_add (
      .a_i (data_in),
      .y_o (wdata)
   );

   assign full  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) &&
                  (wr_ptr_q[IW] != rd_ptr_q[IW]);
   assign empty = (wr_ptr_q == rd_ptr_q);

   assign i_i_ready = ~full;
   assign i_r_ready = ~empty;
   assign insert    = u_i_ready & ~full;
   assign remove    = u_r_ready & ~empty;
   assign count     = cnt_q;

   // While empty, keep showing the most recently consumed word.
   assign data_out = empty ? last_q : mem_q[rd_ptr_q[IW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(insert);
      rd_ptr_d = rd_ptr_q + PW'(remove);
      last_d   = remove ? mem_q[rd_ptr_q[IW-1:0]] : last_q;
      cnt_d    = cnt_q;
      unique case ({insert, remove})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         last_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
      end
   end

   always_ff @(posedge clock) begin
      if (insert) begin
         mem_q[wr_ptr_q[IW-1:0]] <= wdata;
      end
   end

endmodule

// File: tb/tb_isp_offset_fifo.sv
// Directed + random scoreboard bench for isp_offset_fifo.
// Build with ISP_OFFSET_SAT_EN to check the saturating variant.
module tb_isp_offset_fifo;
   import isp_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic       u_i_ready;
   logic       u_r_ready;
   pix_t       data_in;
   pix_t       data_out;
   logic       i_i_ready;
   logic       i_r_ready;
   logic [2:0] count;

   int n_cmp = 0;
   int n_bad = 0;
   int sb[$];
   int last_out = 0;

   isp_offset_fifo dut (
      .clock     (clock),
      .reset     (reset),
      .u_i_ready (u_i_ready),
      .u_r_ready (u_r_ready),
      .data_in   (data_in),
      .data_out  (data_out),
      .i_i_ready (i_i_ready),
      .i_r_ready (i_r_ready),
      .count     (count)
   );

   always #5 clock = ~clock;

   function automatic int expect_of(input int d);
`ifdef ISP_OFFSET_SAT_EN
      return (d + 1 > 255) ? 255 : d + 1;
`else
      return (d + 1) & 255;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge: check state, drive, clock, update model.
   task automatic cyc(input logic ui, input logic ur, input int din);
      bit ins, rem;
      chk("count", 32'(count), 32'(sb.size()));
      chk("i_i_ready", 32'(i_i_ready), 32'(sb.size() != 4));
      chk("i_r_ready", 32'(i_r_ready), 32'(sb.size() != 0));
      if (sb.size() == 0)
         chk("hold", 32'(data_out), 32'(last_out));
      ins = ui && (sb.size() < 4);
      rem = ur && (sb.size() > 0);
      u_i_ready = ui;
      u_r_ready = ur;
      data_in   = pix_t'(din);
      if (rem) begin
         last_out = sb.pop_front();
         chk("data_out", 32'(data_out), 32'(last_out));
      end else if (sb.size() > 0) begin
         chk("head", 32'(data_out), 32'(sb[0]));
      end
      @(posedge clock);
      if (ins) sb.push_back(expect_of(din));
      @(negedge clock);
   endtask

   initial begin
      reset     = 1'b1;
      u_i_ready = 1'b0;
      u_r_ready = 1'b0;
      data_in   = '0;
      repeat (3) @(negedge clock);
      chk("rst_count", 32'(count), 0);
      chk("rst_iir", 32'(i_i_ready), 1);
      chk("rst_irr", 32'(i_r_ready), 0);
      chk("rst_dout", 32'(data_out), 0);
      reset = 1'b0;
      @(negedge clock);

      // Async reset with three words buffered
      cyc(1, 0, 5);
      cyc(1, 0, 6);
      cyc(1, 0, 7);
      chk("pre_rst_count", 32'(count), 3);
      #2 reset = 1'b1;
      #1;
      chk("arst_count", 32'(count), 0);
      chk("arst_irr", 32'(i_r_ready), 0);
      chk("arst_iir", 32'(i_i_ready), 1);
      chk("arst_dout", 32'(data_out), 0);
      sb.delete();
      last_out = 0;
      u_i_ready = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // Fill, ignored overflow insert, drain
      cyc(1, 0, 10);
      cyc(1, 0, 20);
      cyc(1, 0, 30);
      cyc(1, 0, 40);
      chk("full_count", 32'(count), 4);
      chk("full_iir", 32'(i_i_ready), 0);
      cyc(1, 0, 50);
      chk("no_5th", 32'(count), 4);
      for (int i = 0; i < 5; i++) cyc(0, 1, 0);
      chk("drained_irr", 32'(i_r_ready), 0);
      chk("drained_hold", 32'(data_out), 41);

      // Streaming with wrap-around
      for (int i = 0; i < 20; i++) cyc(1, 1, i);
      for (int i = 0; i < 2; i++) cyc(0, 1, 0);

      // Offset arithmetic boundary
      cyc(1, 0, 255);
      cyc(1, 0, 254);
`ifdef ISP_OFFSET_SAT_EN
      chk("ovf_255", 32'(data_out), 255);
`else
      chk("ovf_255", 32'(data_out), 0);
`endif
      cyc(0, 1, 0);
      chk("ovf_254", 32'(data_out), 255);
      cyc(0, 1, 0);

      // Full boundary with simultaneous requests
      for (int i = 0; i < 4; i++) cyc(1, 0, 100 + i);
      cyc(1, 1, 200);
      chk("full_rm_only", 32'(count), 3);
      cyc(1, 0, 201);
      chk("refill", 32'(count), 4);
      for (int i = 0; i < 5; i++) cyc(0, 1, 0);

      // Random stall traffic
      for (int i = 0; i < 1000; i++)
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 255)));
      while (sb.size() > 0) cyc(0, 1, 0);
      cyc(0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
